// File: rtl/display_bcd_driver.sv
// Sequential double-dabble binary-to-BCD converter driving tens/units/minus seven-segment digits.
// Result lands WIDTH+1 clocks after an accepted start; start is ignored while busy (no queueing).
module display_bcd_driver #(
   parameter int WIDTH          = 6,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] mag,
   input  logic             sign,
   input  logic             start,
   output logic [6:0]       hex_tens,
   output logic [6:0]       hex_units,
   output logic [6:0]       hex_sign,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   // XOR mask that turns active-high patterns into board polarity; also the blank code.
   localparam logic [6:0] SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [6:0] SEG_G    = 7'h40;
   localparam logic [2:0] CNT_INIT = 3'(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [7:0]       bcd;
   logic [2:0]       cnt;
   logic             sign_q;

   logic             capture;
   logic             step;
   logic             load;
   logic [3:0]       units_adj;
   logic [3:0]       tens_adj;
   logic [7:0]       bcd_shifted;

   function automatic logic [6:0] seg_of(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (cnt == 3'd1) state_next = LOAD;
         LOAD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy    = 1'b0;
      capture = 1'b0;
      step    = 1'b0;
      load    = 1'b0;
      case (state)
         IDLE:    capture = start;
         SHIFT: begin
            busy = 1'b1;
            step = 1'b1;
         end
         LOAD: begin
            busy = 1'b1;
            load = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // Both nibbles are corrected from the same pre-shift value before the joint shift.
   always_comb begin
      units_adj   = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
      tens_adj    = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
      bcd_shifted = {tens_adj[2:0], units_adj, shift_reg[WIDTH-1]};
   end

   // Conversion datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bcd       <= 8'h00;
         cnt       <= 3'd0;
         sign_q    <= 1'b0;
      end else if (capture) begin
         shift_reg <= mag;
         sign_q    <= sign;
         bcd       <= 8'h00;
         cnt       <= CNT_INIT;
      end else if (step) begin
         shift_reg <= shift_reg << 1;
         bcd       <= bcd_shifted;
         cnt       <= cnt - 3'd1;
      end
   end

   // Display registers only move on the LOAD edge so the digits never flicker mid-conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_tens  <= SEG_INV;
         hex_units <= SEG_INV;
         hex_sign  <= SEG_INV;
         done      <= 1'b0;
      end else begin
         done <= load;
         if (load) begin
            hex_tens  <= (bcd[7:4] == 4'd0) ? SEG_INV : (seg_of(bcd[7:4]) ^ SEG_INV);
            hex_units <= seg_of(bcd[3:0]) ^ SEG_INV;
            hex_sign  <= (sign_q && (bcd != 8'h00)) ? (SEG_G ^ SEG_INV) : SEG_INV;
         end
      end
   end

endmodule

// File: tb/tb_display_bcd_driver.sv
// Scoreboard bench for display_bcd_driver: directed conversions on an active-low and an active-high build.
module tb_display_bcd_driver;

   localparam int W = 6;

   typedef struct {
      logic [6:0] tens;
      logic [6:0] units;
      logic [6:0] sgn;
      int         start_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] mag0 = '0, mag1 = '0;
   logic       sign0 = 1'b0, sign1 = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [6:0] hex_tens0, hex_units0, hex_sign0;
   logic [6:0] hex_tens1, hex_units1, hex_sign1;
   logic       busy0, done0, busy1, done1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [6:0] last_t = 7'h7F, last_u = 7'h7F, last_s = 7'h7F;
   logic prev_done0 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   display_bcd_driver #(.WIDTH(W), .SEG_ACTIVE_LOW(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .mag(mag0), .sign(sign0), .start(start0),
      .hex_tens(hex_tens0), .hex_units(hex_units0), .hex_sign(hex_sign0),
      .busy(busy0), .done(done0)
   );

   display_bcd_driver #(.WIDTH(W), .SEG_ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .mag(mag1), .sign(sign1), .start(start1),
      .hex_tens(hex_tens1), .hex_units(hex_units1), .hex_sign(hex_sign1),
      .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Monitor for the active-low instance: pops on every done pulse, and checks display hold while busy.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done0) begin
            check("done_single_pulse", 32'(prev_done0), 32'd0);
            if (q0.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q0.pop_front();
               check("hex_tens", 32'(hex_tens0), 32'(e.tens));
               check("hex_units", 32'(hex_units0), 32'(e.units));
               check("hex_sign", 32'(hex_sign0), 32'(e.sgn));
               check("latency", 32'(cyc - e.start_cyc), 32'(W + 1));
               last_t = e.tens;
               last_u = e.units;
               last_s = e.sgn;
            end
         end else if (busy0) begin
            check("hold_during_busy", 32'({hex_tens0, hex_units0, hex_sign0}),
                  32'({last_t, last_u, last_s}));
         end
      end
      prev_done0 = done0;
   end

   // Monitor for the active-high instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done1) begin
         if (q1.size() == 0) begin
            check("unexpected_done_ah", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("ah_hex_tens", 32'(hex_tens1), 32'(e.tens));
            check("ah_hex_units", 32'(hex_units1), 32'(e.units));
            check("ah_hex_sign", 32'(hex_sign1), 32'(e.sgn));
            check("ah_latency", 32'(cyc - e.start_cyc), 32'(W + 1));
         end
      end
   end

   task automatic issue0(input logic [5:0] m, input logic s,
                         input logic [6:0] et, input logic [6:0] eu, input logic [6:0] es);
      @(negedge clk);
      mag0   = m;
      sign0  = s;
      start0 = 1'b1;
      q0.push_back('{et, eu, es, cyc + 1});
      @(negedge clk);
      start0 = 1'b0;
      mag0   = ~m;
      sign0  = ~s;
   endtask

   task automatic wait_done0();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done0 && n < 40);
      if (!done0) check("timeout_done0", 32'd0, 32'd1);
   endtask

   task automatic wait_done1();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done1 && n < 40);
      if (!done1) check("timeout_done1", 32'd0, 32'd1);
   endtask

   initial begin
      // Reset held, then released with no start: everything blank and quiet.
      repeat (3) @(negedge clk);
      check("rst_tens_ah", 32'(hex_tens1), 32'h00);
      check("rst_sign_ah", 32'(hex_sign1), 32'h00);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_tens", 32'(hex_tens0), 32'h7F);
         check("idle_units", 32'(hex_units0), 32'h7F);
         check("idle_sign", 32'(hex_sign0), 32'h7F);
         check("idle_busy_done", 32'({busy0, done0}), 32'd0);
      end

      // -32: busy for exactly W+1 cycles, then done.
      issue0(6'd32, 1'b1, 7'h30, 7'h24, 7'h3F);
      for (int i = 0; i < W + 1; i++) begin
         check("busy_high", 32'(busy0), 32'd1);
         check("done_low_while_busy", 32'(done0), 32'd0);
         @(negedge clk);
      end
      check("busy_low_at_done", 32'(busy0), 32'd0);
      check("done_at_k7", 32'(done0), 32'd1);

      // Negative zero shows a plain 0.
      issue0(6'd0, 1'b1, 7'h7F, 7'h40, 7'h7F);
      wait_done0();

      // Start held through busy: only the latched 15 converts, then 9 is taken right after done.
      @(negedge clk);
      mag0   = 6'd15;
      sign0  = 1'b0;
      start0 = 1'b1;
      q0.push_back('{7'h79, 7'h12, 7'h7F, cyc + 1});
      @(negedge clk);
      mag0 = 6'd9;
      wait_done0();
      q0.push_back('{7'h7F, 7'h10, 7'h7F, cyc + 1});
      @(negedge clk);
      start0 = 1'b0;
      check("b2b_busy", 32'(busy0), 32'd1);
      wait_done0();

      // Reset in the middle of converting -27 blanks everything, no done.
      @(negedge clk);
      mag0   = 6'd27;
      sign0  = 1'b1;
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_tens", 32'(hex_tens0), 32'h7F);
      check("abort_units", 32'(hex_units0), 32'h7F);
      check("abort_sign", 32'(hex_sign0), 32'h7F);
      check("abort_busy_done", 32'({busy0, done0}), 32'd0);
      last_t = 7'h7F;
      last_u = 7'h7F;
      last_s = 7'h7F;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_abort_quiet", 32'({busy0, done0}), 32'd0);
      end
      issue0(6'd7, 1'b1, 7'h7F, 7'h78, 7'h3F);
      wait_done0();

      // Active-high build with the largest magnitude.
      @(negedge clk);
      mag1   = 6'd63;
      sign1  = 1'b0;
      start1 = 1'b1;
      q1.push_back('{7'h7D, 7'h4F, 7'h00, cyc + 1});
      @(negedge clk);
      start1 = 1'b0;
      mag1   = 6'd0;
      wait_done1();

      repeat (3) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
